// File: rtl/reg_src_const_unit.sv
// Operand source mux: passes in_data through or substitutes a writable constant-table entry.
// Latency: 1 cycle from accept to out_data; sustains one result per cycle.
// Backpressure: single output register; in_ready = !out_valid || out_ready, so a stall holds the result.
module reg_src_const_unit #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_const,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [15:0]      const_cnt
);

    localparam int DEPTH = 2 ** SEL_W;

    // Power-on constant set; entry 0 stands for pass-through and is never read.
    function automatic logic [WIDTH-1:0] rst_val(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        case (k)
            2:       v = WIDTH'(1);
            3:       v = WIDTH'(3);
            4:       v = WIDTH'(6);
            5:       v = WIDTH'(7);
            6:       v = WIDTH'(2);
            7:       v = WIDTH'(4);
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] tbl_d [DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_is_const_q, out_is_const_d;
    logic [15:0]      const_cnt_q, const_cnt_d;
    logic             accept;

    assign in_ready     = !out_valid_q || out_ready;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_is_const = out_is_const_q;
    assign const_cnt    = const_cnt_q;

    // Next-state: capture on accept (reading the pre-write table), drain on consume, apply config writes.
    always_comb begin
        accept         = in_valid && in_ready;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_is_const_d = out_is_const_q;
        const_cnt_d    = const_cnt_q;
        tbl_d          = tbl_q;

        if (accept) begin
            out_valid_d    = 1'b1;
            out_is_const_d = (in_sel != '0);
            out_data_d     = (in_sel == '0) ? in_data : tbl_q[in_sel];
            if ((in_sel != '0) && (const_cnt_q != 16'hFFFF)) begin
                const_cnt_d = const_cnt_q + 16'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Entry 0 is the pass-through slot, so writes to it are dropped.
        if (cfg_we && (cfg_addr != '0)) begin
            tbl_d[cfg_addr] = cfg_data;
        end
    end

    // State registers; reset reloads the constant table and discards any held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_is_const_q <= 1'b0;
            const_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= rst_val(i);
            end
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_is_const_q <= out_is_const_d;
            const_cnt_q    <= const_cnt_d;
            tbl_q          <= tbl_d;
        end
    end

endmodule

// File: tb/tb_reg_src_const_unit.sv
// Directed bench for reg_src_const_unit.
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: out_ready driven directly to exercise stalls.
module tb_reg_src_const_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_is_const;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [15:0] const_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_tbl [8];

    reg_src_const_unit #(.WIDTH(16), .SEL_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_is_const (out_is_const),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .const_cnt    (const_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_tbl[0] = 16'h0000; exp_tbl[1] = 16'h0000; exp_tbl[2] = 16'h0001; exp_tbl[3] = 16'h0003;
        exp_tbl[4] = 16'h0006; exp_tbl[5] = 16'h0007; exp_tbl[6] = 16'h0002; exp_tbl[7] = 16'h0004;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0;
        out_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_is_const", out_is_const, 0);
        chk("rst_const_cnt", const_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // Pass-through of register operand
        out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd0; in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        chk("pt_out_data", out_data, 16'hBEEF);
        chk("pt_is_const", out_is_const, 0);
        chk("pt_out_valid", out_valid, 1);
        chk("pt_const_cnt", const_cnt, 0);

        // Back-to-back sweep of table entries
        for (int k = 1; k < 8; k++) begin
            in_valid = 1'b1; in_sel = 3'(k); in_data = 16'hA5A5;
            step();
            chk($sformatf("sweep_data_%0d", k), out_data, exp_tbl[k]);
            chk($sformatf("sweep_valid_%0d", k), out_valid, 1);
        end
        in_valid = 1'b0;
        chk("sweep_is_const", out_is_const, 1);
        chk("sweep_const_cnt", const_cnt, 7);
        step();
        chk("drain_out_valid", out_valid, 0);

        // Stall with table write underneath the held result
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd4;
        step();
        in_valid = 1'b1; in_sel = 3'd0; in_data = 16'hAAAA;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall_data_%0d", c), out_data, 16'h0006);
            chk($sformatf("stall_in_ready_%0d", c), in_ready, 0);
        end
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 16'h0055;
        step();
        cfg_we = 1'b0;
        chk("stall_wr_data", out_data, 16'h0006);
        chk("stall_wr_in_ready", in_ready, 0);
        chk("stall_cnt", const_cnt, 8);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        in_valid = 1'b1; in_sel = 3'd4;
        step();
        chk("new4_data", out_data, 16'h0055);
        chk("new4_is_const", out_is_const, 1);
        chk("new4_cnt", const_cnt, 9);

        // Same-cycle write and accept of one entry
        in_valid = 1'b1; in_sel = 3'd2;
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 16'h1234;
        step();
        cfg_we = 1'b0;
        chk("wr_acc_old", out_data, 16'h0001);
        step();
        chk("wr_acc_new", out_data, 16'h1234);
        chk("wr_acc_cnt", const_cnt, 11);

        // Writes to entry 0 are ignored
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'hFFFF;
        step();
        cfg_we = 1'b0;
        in_valid = 1'b1; in_sel = 3'd0; in_data = 16'h0003;
        step();
        in_valid = 1'b0;
        chk("addr0_data", out_data, 16'h0003);
        chk("addr0_is_const", out_is_const, 0);
        chk("addr0_cnt", const_cnt, 11);

        // Reset during a stall with entry 3 modified
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 16'h00AA;
        step();
        cfg_we = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd3;
        step();
        in_valid = 1'b0;
        chk("mod3_data", out_data, 16'h00AA);
        step();
        chk("mod3_stall_valid", out_valid, 1);
        reset = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 16'h9999;
        in_valid = 1'b1; in_sel = 3'd5; out_ready = 1'b1;
        step();
        reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_data", out_data, 0);
        chk("rst2_const_cnt", const_cnt, 0);
        chk("rst2_in_ready", in_ready, 1);
        in_valid = 1'b1; in_sel = 3'd3;
        step();
        chk("rst2_sel3", out_data, 16'h0003);
        in_sel = 3'd5;
        step();
        in_valid = 1'b0;
        chk("rst2_sel5", out_data, 16'h0007);
        chk("rst2_cnt", const_cnt, 2);
        step();
        chk("final_drain", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_src_const_unit.md
REG_SRC_CONST_UNIT -- requirements
Module: reg_src_const_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-002 The block SHALL have parameter SEL_W, default 3, giving the selector width; the constant table has 2**SEL_W entries, and entry 0 is reserved for pass-through.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_data/in_sel are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts input this cycle.
REQ-007 Port in_data, input, WIDTH: register-file operand.
REQ-008 Port in_sel, input, SEL_W: source select; 0 selects in_data, k>0 selects table entry k.
REQ-009 Port out_valid, output, 1: out_data holds a result.
REQ-010 Port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-011 Port out_data, output, WIDTH: registered selected operand.
REQ-012 Port out_is_const, output, 1: out_data came from the table (captured sel != 0).
REQ-013 Port cfg_we, input, 1: table write strobe.
REQ-014 Port cfg_addr, input, SEL_W: table entry to write.
REQ-015 Port cfg_data, input, WIDTH: value to write.
REQ-016 Port const_cnt, output, 16: saturating count of accepted constant selections.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 An accept SHALL occur when in_valid && in_ready; out_data, out_is_const and out_valid=1 are registered on the next edge, giving 1-cycle latency.
REQ-019 If out_valid && !out_ready, out_data and out_is_const SHALL hold stable and no input is accepted.
REQ-020 If out_valid && out_ready && !in_valid, out_valid SHALL clear on the next edge.
REQ-021 Back-to-back accepts with out_ready held high SHALL sustain 1 result per cycle.
REQ-022 Table reset contents for entries 1..7 SHALL be 0, 1, 3, 6, 7, 2, 4, zero-extended to WIDTH; for SEL_W>3, entries 8 and above reset to 0; for SEL_W<3, only the entries that exist are loaded.
REQ-023 A cfg_we write SHALL update entry cfg_addr on the clock edge; cfg_we with cfg_addr=0 is ignored.
REQ-024 For a write and an accept to the same entry in the same cycle, the accept SHALL capture the old value; the new value applies from the following cycle.
REQ-025 Table writes SHALL proceed regardless of handshake state, including during a stall, and SHALL NOT alter an already-registered out_data.
REQ-026 const_cnt SHALL increment by 1 on each accept with in_sel != 0 and saturate at 16'hFFFF.

Reset
REQ-027 While reset=1 at a clock edge: out_valid=0, out_data=0, out_is_const=0, const_cnt=0, and the table is reloaded per REQ-022; all input and config activity that cycle is ignored.
REQ-028 Reset asserted mid-stall SHALL discard the held result; in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-029 After reset, accept sel=0, data=16'hBEEF -> next cycle out_data=16'hBEEF, out_is_const=0, out_valid=1.
REQ-030 Sweep sel=1..7 with out_ready=1 -> out_data sequence 0,1,3,6,7,2,4 on consecutive cycles; const_cnt=7.
REQ-031 Accept sel=4 with out_ready=0 for 3 cycles, then drive cfg write addr=4 data=16'h0055 -> out_data stays 6 and in_ready=0 until out_ready=1; a later sel=4 yields 16'h0055.
REQ-032 In one cycle, cfg write addr=2 data=16'h1234 and accept sel=2 -> out_data=1; the next accept with sel=2 -> 16'h1234.
REQ-033 cfg write addr=0 data=16'hFFFF, then accept sel=0 data=16'h0003 -> out_data=16'h0003.
REQ-034 Assert reset during a stall with entry 3 modified -> out_valid=0, const_cnt=0, and sel=3 then yields 16'h0003.
